rr_resource_arbiter: RTL and testbench
======================================

# rr_resource_arbiter

Round-robin arbiter that shares one single-ported execution/writeback resource among `NUM_REQ` requesters. Grants are registered and presented both one-hot and as an encoded integer index. The index is formed by OR-reduction of the one-hot grant, which is legal because the grant is always one-hot or zero. A granted requester holds the resource until the consumer acknowledges it. An optional lock lets a requester keep the resource for a bounded burst.

## Interface
- `NUM_REQ`, 4: number of requesters; must be ≥2.
- `MAX_HOLD`, 4: maximum consecutive grants to one locked requester; must be ≥1.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `request`  in  NUM_REQ  per-requester request. Must stay asserted until acked.
- `lock`  in  NUM_REQ  per-requester burst-lock hint. Sampled only on ack of that requester.
- `grant_ack`  in  1  consumer accepts current grant this cycle. Ignored when `grant_valid`=0.
- `grant_valid`  out  1  a grant is active.
- `grant_onehot`  out  NUM_REQ  granted requester; all-zero when `grant_valid`=0.
- `grant_id`  out  $clog2(NUM_REQ)  integer index of `grant_onehot`; 0 when idle.

## Operation
- Internal state:
  - `prio_ptr`: $clog2(NUM_REQ) bits; index of the highest-priority requester.
  - `hold_cnt`: $clog2(MAX_HOLD+1) bits.
  - FSM with states IDLE, GRANTED, LOCKED.
- Selection:
  - First asserted `request` bit, scanning upward from `prio_ptr` with wrap-around modulo NUM_REQ.
  - Produces a one-hot vector, which is registered.
  - `grant_id` is registered from the encoded one-hot; it never depends combinationally on inputs.
- IDLE:
  - If any `request` is set → select, load grant, `hold_cnt`=1, go to GRANTED.
  - Otherwise stay in IDLE with outputs zero.
- GRANTED / LOCKED, no ack:
  - Grant held stable regardless of `request`/`lock` changes.
- GRANTED / LOCKED, on `grant_ack`:
  - `prio_ptr` ← (granted id + 1) mod NUM_REQ.
  - If `lock[g]` & `request[g]` & `hold_cnt` < MAX_HOLD:
    - Keep grant `g`, `hold_cnt`++, go to LOCKED.
    - `prio_ptr` is still advanced, so fairness resumes after the burst.
  - Else if any `request` other than the one just acked is set:
    - Re-select with the updated pointer.
    - New grant in the next cycle (no bubble), `hold_cnt`=1, go to GRANTED.
    - The acked requester's `request` bit is masked in that cycle.
  - Else → IDLE; outputs cleared next cycle.
- A requester dropping `request` while granted without ack is a protocol violation. Simulation assertion flags it; the grant is unaffected.
- Assertions:
  - `$onehot0(grant_onehot)` every cycle.
  - `grant_valid` == |`grant_onehot`.

## Timing
- Reset (async assert, sync-release assumed upstream), all of:
  - `grant_valid`=0, `grant_onehot`=0, `grant_id`=0.
  - `prio_ptr`=0, `hold_cnt`=0, FSM=IDLE.
- Reset asserted mid-grant: outputs clear immediately (asynchronously); the pending grant is discarded.
- Request-to-grant latency: 1 cycle (request seen at cycle t → `grant_valid` at t+1).
- Ack-to-next-grant: 1 cycle; sustained throughput is one grant per cycle with ack held high.
- Ack and a new request arriving in the same cycle: the new request competes in that cycle's selection.
- Pointer wrap: granted id NUM_REQ-1 → `prio_ptr`=0.

## Configuration
- `RR_ARB_LOCK_EN` defined:
  - LOCKED state, `hold_cnt` and the lock path are present as described.
- `RR_ARB_LOCK_EN` undefined:
  - `lock` is ignored and LOCKED is unreachable (not synthesized).
  - `hold_cnt` is removed.
  - Every ack re-arbitrates: strict round-robin.

## Test plan
- Reset, async deassert-to-assert mid-run:
  - Hold `rst_n`=0 with `request`=4'b1111 → all outputs 0.
  - Assert `rst_n` low while `grant_id`=2 → outputs 0 within the same cycle, no clock edge needed.
  - Release → grant to 0 one cycle later.
- Single requester, `request`=4'b0100 at cycle 5 → `grant_valid`=1, `grant_onehot`=4'b0100, `grant_id`=2 at cycle 6. Ack at 6 with request dropped → IDLE and outputs 0 at 7.
- Round-robin:
  - `request`=4'b1111, `grant_ack`=1 every cycle, `lock`=0 → `grant_id` sequence 0,1,2,3,0,1 with no idle cycles.
- Backpressure:
  - `request`=4'b1010, `grant_ack`=0 for 5 cycles → `grant_id`=1 stable for all 5 cycles.
  - Ack → `grant_id`=3 next cycle.
- Lock (`RR_ARB_LOCK_EN`, MAX_HOLD=2):
  - `request`=4'b0011, `lock`=4'b0001, ack every cycle → `grant_id` 0,0,1,0,0,1…
  - Without the macro → 0,1,0,1.
- Wrap and masking:
  - `prio_ptr`=3 after grant 2, `request`=4'b0101 → grant 0 (wrap).
  - Ack of 0 while `request`=4'b0101 → grant 2 next, not 0.

Source files
------------

// File: rtl/rr_resource_arbiter_if.sv
// Request/grant bundle between requesters (master) and rr_resource_arbiter (slave).
interface rr_resource_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] request;
    logic [NUM_REQ-1:0] lock;
    logic               grant_ack;
    logic               grant_valid;
    logic [NUM_REQ-1:0] grant_onehot;
    logic [ID_W-1:0]    grant_id;

    modport master (
        output request,
        output lock,
        output grant_ack,
        input  grant_valid,
        input  grant_onehot,
        input  grant_id
    );

    modport slave (
        input  request,
        input  lock,
        input  grant_ack,
        output grant_valid,
        output grant_onehot,
        output grant_id
    );
endinterface

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter for one shared execution/writeback resource, registered grants.
// Optional burst lock is built only when RR_ARB_LOCK_EN is defined.
module rr_resource_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    rr_resource_arbiter_if.slave bus
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("rr_resource_arbiter: NUM_REQ must be >= 2");
    end
    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("rr_resource_arbiter: MAX_HOLD must be >= 1");
    end

`ifdef RR_ARB_LOCK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, GRANTED = 2'd1, LOCKED = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, GRANTED = 2'd1} state_t;
`endif

    state_t             state;
    state_t             state_nxt;
    logic [NUM_REQ-1:0] grant_onehot_p0;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [ID_W-1:0]    grant_id_p0;
    logic [ID_W-1:0]    id_nxt;
    logic [ID_W-1:0]    prio_ptr;
    logic [ID_W-1:0]    ptr_nxt;
`ifdef RR_ARB_LOCK_EN
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_nxt;
`endif

    logic [NUM_REQ-1:0] others;
    logic               any_other;
    logic [ID_W-1:0]    ptr_adv;
    logic               lock_keep;
    logic [NUM_REQ-1:0] sel_req;
    logic [ID_W-1:0]    sel_ptr;
    logic [NUM_REQ-1:0] sel;

    // First set bit of req, scanning upward from ptr with wrap-around.
    function automatic logic [NUM_REQ-1:0] rr_select(input logic [NUM_REQ-1:0] req,
                                                     input logic [ID_W-1:0]    ptr);
        logic [NUM_REQ-1:0] pick;
        logic               found;
        int                 idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

    // OR-reduction encoder; valid only because the input is one-hot or zero.
    function automatic logic [ID_W-1:0] onehot_to_id(input logic [NUM_REQ-1:0] oh);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            id = id | (oh[i] ? ID_W'(i) : '0);
        end
        return id;
    endfunction

    assign others    = bus.request & ~grant_onehot_p0;
    assign any_other = |others;
    assign ptr_adv   = (grant_id_p0 == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_p0 + ID_W'(1);

`ifdef RR_ARB_LOCK_EN
    assign lock_keep = (|(bus.lock & bus.request & grant_onehot_p0)) &&
                       (hold_cnt < HOLD_W'(MAX_HOLD));
`else
    logic lock_unused;
    assign lock_keep   = 1'b0;
    assign lock_unused = (^bus.lock) ^ (MAX_HOLD > 0) ^ (HOLD_W > 0);
`endif

    // A single selector serves both the idle pick and the re-arbitration on ack.
    assign sel_req = (state == IDLE) ? bus.request : others;
    assign sel_ptr = (state == IDLE) ? prio_ptr    : ptr_adv;
    assign sel     = rr_select(sel_req, sel_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            grant_onehot_p0 <= '0;
            grant_id_p0     <= '0;
            prio_ptr        <= '0;
`ifdef RR_ARB_LOCK_EN
            hold_cnt        <= '0;
`endif
        end else begin
            state           <= state_nxt;
            grant_onehot_p0 <= grant_nxt;
            grant_id_p0     <= id_nxt;
            prio_ptr        <= ptr_nxt;
`ifdef RR_ARB_LOCK_EN
            hold_cnt        <= hold_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (|bus.request) state_nxt = GRANTED;
            end
            default: begin
                if (bus.grant_ack) begin
`ifdef RR_ARB_LOCK_EN
                    if (lock_keep)      state_nxt = LOCKED;
                    else if (any_other) state_nxt = GRANTED;
                    else                state_nxt = IDLE;
`else
                    if (any_other)      state_nxt = GRANTED;
                    else                state_nxt = IDLE;
`endif
                end
            end
        endcase
    end

    always_comb begin
        grant_nxt = grant_onehot_p0;
        id_nxt    = grant_id_p0;
        ptr_nxt   = prio_ptr;
`ifdef RR_ARB_LOCK_EN
        hold_nxt  = hold_cnt;
`endif
        if (state == IDLE) begin
            if (|bus.request) begin
                grant_nxt = sel;
                id_nxt    = onehot_to_id(sel);
`ifdef RR_ARB_LOCK_EN
                hold_nxt  = HOLD_W'(1);
`endif
            end
        end else if (bus.grant_ack) begin
            // Pointer advances even when a lock keeps the grant, so fairness resumes after the burst.
            ptr_nxt = ptr_adv;
            if (lock_keep) begin
`ifdef RR_ARB_LOCK_EN
                hold_nxt = hold_cnt + HOLD_W'(1);
`endif
            end else if (any_other) begin
                grant_nxt = sel;
                id_nxt    = onehot_to_id(sel);
`ifdef RR_ARB_LOCK_EN
                hold_nxt  = HOLD_W'(1);
`endif
            end else begin
                grant_nxt = '0;
                id_nxt    = '0;
`ifdef RR_ARB_LOCK_EN
                hold_nxt  = '0;
`endif
            end
        end
    end

    assign bus.grant_valid  = (state != IDLE);
    assign bus.grant_onehot = grant_onehot_p0;
    assign bus.grant_id     = grant_id_p0;

    a_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.grant_onehot));
    a_valid_matches: assert property (@(posedge clk) disable iff (!rst_n)
        bus.grant_valid == (|bus.grant_onehot));
    a_request_held: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.grant_valid && !bus.grant_ack) |-> (|(bus.request & bus.grant_onehot)));
endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Self-checking bench for rr_resource_arbiter: directed scenarios plus randomized traffic vs. a reference model.
module tb_rr_resource_arbiter;
    localparam int N    = 4;
    localparam int MAXH = 2;

    logic clk = 1'b0;
    logic rst_n;

    rr_resource_arbiter_if #(.NUM_REQ(N)) bus ();

    rr_resource_arbiter #(.NUM_REQ(N), .MAX_HOLD(MAXH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who holds the resource, where priority starts, burst length so far.
    int m_busy, m_g, m_ptr, m_hold;

    function automatic void m_reset();
        m_busy = 0; m_g = 0; m_ptr = 0; m_hold = 0;
    endfunction

    function automatic int first_from(logic [N-1:0] req, int p);
        for (int k = 0; k < N; k++) if (req[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    function automatic void model_clock(logic [N-1:0] req, logic [N-1:0] lk, logic ack);
        logic [N-1:0] rest;
        logic         lock_ok;
        if (m_busy == 0) begin
            if (req != 0) begin
                m_g = first_from(req, m_ptr); m_busy = 1; m_hold = 1;
            end
        end else if (ack) begin
            m_ptr   = (m_g + 1) % N;
            lock_ok = lk[m_g] && req[m_g] && (m_hold < MAXH);
`ifndef RR_ARB_LOCK_EN
            lock_ok = 1'b0;
`endif
            if (lock_ok) begin
                m_hold = m_hold + 1;
            end else begin
                rest = req; rest[m_g] = 1'b0;
                if (rest != 0) begin
                    m_g = first_from(rest, m_ptr); m_hold = 1;
                end else begin
                    m_busy = 0; m_g = 0; m_hold = 0;
                end
            end
        end
    endfunction

    function automatic logic [6:0] exp_vec();
        logic [3:0] oh;
        logic [1:0] id;
        oh = (m_busy != 0) ? 4'(1 << m_g) : 4'b0;
        id = (m_busy != 0) ? 2'(m_g) : 2'b0;
        return {(m_busy != 0), oh, id};
    endfunction

    function automatic logic [6:0] dut_vec();
        return {bus.grant_valid, bus.grant_onehot, bus.grant_id};
    endfunction

    task automatic step();
        if (rst_n) model_clock(bus.request, bus.lock, bus.grant_ack);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.request = '0; bus.lock = '0; bus.grant_ack = 1'b0;
        m_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.request = 4'b1111; bus.lock = '0; bus.grant_ack = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (dut_vec() !== 7'b0) begin
            n_fail++; $display("FAIL reset_hold: got %b want %b", dut_vec(), 7'b0);
        end
        rst_n = 1'b1;
        step();
        n_tests++;
        if (dut_vec() !== 7'b1_0001_00) begin
            n_fail++; $display("FAIL reset_first_grant: got %b want %b", dut_vec(), 7'b1_0001_00);
        end
        bus.grant_ack = 1'b1;
        step(); step();
        n_tests++;
        if (dut_vec() !== 7'b1_0100_10) begin
            n_fail++; $display("FAIL reset_pre_grant2: got %b want %b", dut_vec(), 7'b1_0100_10);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (dut_vec() !== 7'b0) begin
            n_fail++; $display("FAIL reset_async_clear: got %b want %b", dut_vec(), 7'b0);
        end
        bus.grant_ack = 1'b0;
        m_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        n_tests++;
        if (dut_vec() !== 7'b1_0001_00) begin
            n_fail++; $display("FAIL reset_release_grant: got %b want %b", dut_vec(), 7'b1_0001_00);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.request = 4'b0100;
        step();
        n_tests++;
        if (dut_vec() !== 7'b1_0100_10) begin
            n_fail++; $display("FAIL single_grant: got %b want %b", dut_vec(), 7'b1_0100_10);
        end
        bus.grant_ack = 1'b1; bus.request = 4'b0000;
        step();
        n_tests++;
        if (dut_vec() !== 7'b0) begin
            n_fail++; $display("FAIL single_idle: got %b want %b", dut_vec(), 7'b0);
        end
        bus.grant_ack = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_id[6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        bus.request = 4'b1111; bus.grant_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_tests++;
            if ({bus.grant_valid, bus.grant_id} !== {1'b1, 2'(exp_id[i])}) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: got v=%b id=%0d want v=1 id=%0d",
                         i, bus.grant_valid, bus.grant_id, exp_id[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.request = 4'b1010; bus.grant_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if (dut_vec() !== 7'b1_0010_01) begin
                n_fail++; $display("FAIL backpressure_hold[%0d]: got %b want %b", i, dut_vec(), 7'b1_0010_01);
            end
        end
        bus.grant_ack = 1'b1;
        step();
        n_tests++;
        if (dut_vec() !== 7'b1_1000_11) begin
            n_fail++; $display("FAIL backpressure_next: got %b want %b", dut_vec(), 7'b1_1000_11);
        end
    endtask

    task automatic test_lock();
`ifdef RR_ARB_LOCK_EN
        int exp_id[6] = '{0, 0, 1, 0, 0, 1};
`else
        int exp_id[6] = '{0, 1, 0, 1, 0, 1};
`endif
        do_reset();
        bus.request = 4'b0011; bus.lock = 4'b0001; bus.grant_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_tests++;
            if ({bus.grant_valid, bus.grant_id} !== {1'b1, 2'(exp_id[i])}) begin
                n_fail++;
                $display("FAIL lock_seq[%0d]: got v=%b id=%0d want v=1 id=%0d",
                         i, bus.grant_valid, bus.grant_id, exp_id[i]);
            end
        end
        bus.lock = '0;
    endtask

    task automatic test_wrap_mask();
        do_reset();
        bus.request = 4'b0100;
        step();
        n_tests++;
        if (dut_vec() !== 7'b1_0100_10) begin
            n_fail++; $display("FAIL wrap_grant2: got %b want %b", dut_vec(), 7'b1_0100_10);
        end
        bus.request = 4'b0101; bus.grant_ack = 1'b1;
        step();
        n_tests++;
        if (dut_vec() !== 7'b1_0001_00) begin
            n_fail++; $display("FAIL wrap_to_0: got %b want %b", dut_vec(), 7'b1_0001_00);
        end
        step();
        n_tests++;
        if (dut_vec() !== 7'b1_0100_10) begin
            n_fail++; $display("FAIL mask_acked: got %b want %b", dut_vec(), 7'b1_0100_10);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] pend;
        int           was_busy, g;
        logic         acked;
        do_reset();
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            pend = pend | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            bus.request   = pend;
            bus.lock      = 4'($urandom_range(0, 15));
            bus.grant_ack = ($urandom_range(0, 9) < 6);
            was_busy = m_busy; g = m_g; acked = bus.grant_ack;
            step();
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random[%0d]: got %b want %b", c, dut_vec(), exp_vec());
            end
            if (was_busy != 0 && acked && $urandom_range(0, 1) == 1) pend[g] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_lock();
        test_wrap_mask();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
